// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard unit covering load-use bubbles, redirect flushes,
//            memory-wait stalls with a timeout, operand forwarding and a stall counter.
// Revision : 1.0
// ============================================================================
module hazard_ctrl #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use1,
   input  logic             id_use2,
   input  logic [4:0]       ex_rs1,
   input  logic [4:0]       ex_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_memReg,
   input  logic             ex_redirect,
   input  logic [4:0]       mem_rd,
   input  logic             mem_regWr,
   input  logic [4:0]       wb_rd,
   input  logic             wb_regWr,
   input  logic             dmem_req,
   input  logic             dmem_ack,
   input  logic             cnt_clr,
   output logic             stall_if,
   output logic             stall_id,
   output logic             stall_ex,
   output logic             stall_mem,
   output logic             flush_id,
   output logic             flush_ex,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [1:0] c_run     = 2'd0;
   localparam logic [1:0] c_lduse   = 2'd1;
   localparam logic [1:0] c_memwait = 2'd2;
   localparam logic [7:0] c_wait_last = 8'(TIMEOUT - 1);

   logic [1:0]       r_state;
   logic [1:0]       w_next;
   logic [7:0]       r_wcnt;
   logic             r_err;
   logic [CNT_W-1:0] r_cnt;

   logic w_busy;
   logic w_lduse;
   logic w_timeout;
   logic w_hold_all;
   logic w_ld_stall;
   logic w_flush_id;
   logic w_flush_ex;

   assign w_busy  = dmem_req & ~dmem_ack;
   assign w_lduse = ex_memReg && (ex_rd != 5'd0) &&
                    ((id_use1 && (id_rs1 == ex_rd)) || (id_use2 && (id_rs2 == ex_rd)));
   // r_wcnt holds the number of MEMWAIT cycles already completed
   assign w_timeout = (r_state == c_memwait) && !dmem_ack && (r_wcnt == c_wait_last);

   always_comb begin
      w_next     = c_run;
      w_hold_all = 1'b0;
      w_ld_stall = 1'b0;
      w_flush_id = 1'b0;
      w_flush_ex = 1'b0;
      case (r_state)
         c_memwait: begin
            if (!dmem_ack && !w_timeout) begin
               w_hold_all = 1'b1;
               w_next     = c_memwait;
            end
         end
         default: begin
            // LDUSE falls through to the RUN rules, minus load-use re-detection
            if (w_busy) begin
               w_hold_all = 1'b1;
               w_next     = c_memwait;
            end else if (ex_redirect) begin
               w_flush_id = 1'b1;
               w_flush_ex = 1'b1;
            end else if ((r_state == c_run) && w_lduse) begin
               w_ld_stall = 1'b1;
               w_flush_ex = 1'b1;
               w_next     = c_lduse;
            end
         end
      endcase
   end

   assign stall_if  = rst_n & (w_hold_all | w_ld_stall);
   assign stall_id  = rst_n & (w_hold_all | w_ld_stall);
   assign stall_ex  = rst_n & w_hold_all;
   assign stall_mem = rst_n & w_hold_all;
   assign flush_id  = rst_n & w_flush_id;
   assign flush_ex  = rst_n & w_flush_ex;
   assign mem_err   = r_err | w_timeout;
   assign stall_cnt = r_cnt;

   always_comb begin
      fwd_a = 2'b00;
      if (mem_regWr && (mem_rd != 5'd0) && (mem_rd == ex_rs1))
         fwd_a = 2'b01;
      else if (wb_regWr && (wb_rd != 5'd0) && (wb_rd == ex_rs1))
         fwd_a = 2'b10;
   end

   always_comb begin
      fwd_b = 2'b00;
      if (mem_regWr && (mem_rd != 5'd0) && (mem_rd == ex_rs2))
         fwd_b = 2'b01;
      else if (wb_regWr && (wb_rd != 5'd0) && (wb_rd == ex_rs2))
         fwd_b = 2'b10;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_run;
         r_wcnt  <= 8'd0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_err   <= r_err | w_timeout;
         if (r_state != c_memwait)
            r_wcnt <= 8'd0;
         else
            r_wcnt <= r_wcnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (cnt_clr)
         r_cnt <= '0;
      else if (stall_if && !(&r_cnt))
         r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
   end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed self-checking bench for hazard_ctrl (TIMEOUT=4, CNT_W=4).
// Revision : 1.0
// ============================================================================
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
   logic       id_use1, id_use2, ex_memReg, ex_redirect, mem_regWr, wb_regWr;
   logic       dmem_req, dmem_ack, cnt_clr;
   logic       stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, mem_err;
   logic [1:0] fwd_a, fwd_b;
   logic [3:0] stall_cnt;
   logic [5:0] ctl;

   int checks = 0;
   int errors = 0;

   hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_memReg(ex_memReg),
      .ex_redirect(ex_redirect), .mem_rd(mem_rd), .mem_regWr(mem_regWr),
      .wb_rd(wb_rd), .wb_regWr(wb_regWr), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
      .cnt_clr(cnt_clr), .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
      .stall_mem(stall_mem), .flush_id(flush_id), .flush_ex(flush_ex),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex}
   assign ctl = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex};

   task automatic idle();
      id_rs1 = 0; id_rs2 = 0; id_use1 = 0; id_use2 = 0;
      ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_memReg = 0; ex_redirect = 0;
      mem_rd = 0; mem_regWr = 0; wb_rd = 0; wb_regWr = 0;
      dmem_req = 0; dmem_ack = 0; cnt_clr = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lduse(input logic [4:0] rd);
      ex_memReg = 1; ex_rd = rd; id_rs1 = rd; id_use1 = 1;
   endtask

   task automatic clear_cnt();
      cnt_clr = 1; tick(); cnt_clr = 0;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 0;
      dmem_req = 1; ex_redirect = 1; set_lduse(5'd5);
      #1;
      checks++;
      if (ctl !== 6'b000000) begin errors++; $display("FAIL reset_ctl got %b want 000000", ctl); end
      tick();
      checks++;
      if (stall_cnt !== 4'd0 || mem_err !== 1'b0) begin
         errors++; $display("FAIL reset_regs got cnt=%0d err=%b want cnt=0 err=0", stall_cnt, mem_err);
      end
      idle();
      @(negedge clk); rst_n = 1;
      tick();
   endtask

   task automatic test_load_use();
      clear_cnt();
      set_lduse(5'd5); #1;
      checks++;
      if (ctl !== 6'b110001) begin errors++; $display("FAIL lduse_stall got %b want 110001", ctl); end
      tick();
      #1;
      checks++;
      if (ctl !== 6'b000000) begin errors++; $display("FAIL lduse_bubble got %b want 000000", ctl); end
      tick();
      idle(); #1;
      checks++;
      if (ctl !== 6'b000000 || stall_cnt !== 4'd1) begin
         errors++; $display("FAIL lduse_after got ctl=%b cnt=%0d want ctl=000000 cnt=1", ctl, stall_cnt);
      end
      ex_memReg = 1; ex_rd = 0; id_rs1 = 0; id_use1 = 1; #1;
      checks++;
      if (ctl !== 6'b000000) begin errors++; $display("FAIL lduse_r0 got %b want 000000", ctl); end
      ex_rd = 9; id_rs1 = 9; id_use1 = 0; #1;
      checks++;
      if (ctl !== 6'b000000) begin errors++; $display("FAIL lduse_nouse got %b want 000000", ctl); end
      id_rs2 = 9; id_use2 = 1; #1;
      checks++;
      if (ctl !== 6'b110001) begin errors++; $display("FAIL lduse_rs2 got %b want 110001", ctl); end
      tick(); idle(); tick();
   endtask

   task automatic test_forward();
      idle();
      mem_rd = 7; wb_rd = 7; ex_rs1 = 7; mem_regWr = 1; wb_regWr = 1; #1;
      checks++;
      if (fwd_a !== 2'b01) begin errors++; $display("FAIL fwd_mem_prio got %b want 01", fwd_a); end
      mem_regWr = 0; #1;
      checks++;
      if (fwd_a !== 2'b10) begin errors++; $display("FAIL fwd_wb got %b want 10", fwd_a); end
      mem_regWr = 1; mem_rd = 0; wb_rd = 0; ex_rs1 = 0; #1;
      checks++;
      if (fwd_a !== 2'b00) begin errors++; $display("FAIL fwd_r0 got %b want 00", fwd_a); end
      mem_rd = 9; ex_rs2 = 9; wb_rd = 9; ex_rs1 = 3; #1;
      checks++;
      if (fwd_b !== 2'b01 || fwd_a !== 2'b00) begin
         errors++; $display("FAIL fwd_b_mem got a=%b b=%b want a=00 b=01", fwd_a, fwd_b);
      end
      mem_rd = 4; #1;
      checks++;
      if (fwd_b !== 2'b10) begin errors++; $display("FAIL fwd_b_wb got %b want 10", fwd_b); end
      wb_regWr = 0; #1;
      checks++;
      if (fwd_b !== 2'b00) begin errors++; $display("FAIL fwd_b_none got %b want 00", fwd_b); end
      idle();
   endtask

   task automatic test_memwait();
      clear_cnt();
      dmem_req = 1; #1;
      checks++;
      if (ctl !== 6'b111100) begin errors++; $display("FAIL mw_enter got %b want 111100", ctl); end
      tick();
      ex_redirect = 1;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (ctl !== 6'b111100) begin errors++; $display("FAIL mw_hold%0d got %b want 111100", i, ctl); end
         tick();
      end
      dmem_ack = 1; #1;
      checks++;
      if (ctl !== 6'b000000) begin errors++; $display("FAIL mw_ack got %b want 000000", ctl); end
      tick();
      dmem_req = 0; dmem_ack = 0; #1;
      checks++;
      if (ctl !== 6'b000011 || stall_cnt !== 4'd3 || mem_err !== 1'b0) begin
         errors++; $display("FAIL mw_release got ctl=%b cnt=%0d err=%b want 000011 3 0", ctl, stall_cnt, mem_err);
      end
      tick(); idle();
   endtask

   task automatic test_redirect_lduse();
      idle();
      set_lduse(5'd12); ex_redirect = 1; #1;
      checks++;
      if (ctl !== 6'b000011) begin errors++; $display("FAIL redir_prio got %b want 000011", ctl); end
      tick();
      ex_redirect = 0; #1;
      checks++;
      if (ctl !== 6'b110001) begin errors++; $display("FAIL redir_stay_run got %b want 110001", ctl); end
      tick();
      ex_redirect = 1; #1;
      checks++;
      if (ctl !== 6'b000011) begin errors++; $display("FAIL lduse_redir got %b want 000011", ctl); end
      tick(); idle(); tick();
   endtask

   task automatic test_timeout();
      idle();
      dmem_req = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (ctl !== 6'b111100 || mem_err !== 1'b0) begin
            errors++; $display("FAIL to_wait%0d got ctl=%b err=%b want 111100 0", i, ctl, mem_err);
         end
         tick();
      end
      #1;
      checks++;
      if (ctl !== 6'b000000 || mem_err !== 1'b1) begin
         errors++; $display("FAIL to_expire got ctl=%b err=%b want 000000 1", ctl, mem_err);
      end
      tick();
      dmem_req = 0;
      repeat (3) tick();
      checks++;
      if (ctl !== 6'b000000 || mem_err !== 1'b1) begin
         errors++; $display("FAIL to_sticky got ctl=%b err=%b want 000000 1", ctl, mem_err);
      end
      @(negedge clk); rst_n = 0; #1;
      checks++;
      if (mem_err !== 1'b0) begin errors++; $display("FAIL to_rst_clear got %b want 0", mem_err); end
      @(negedge clk); rst_n = 1;
      tick();
   endtask

   task automatic test_reset_abandon();
      idle();
      dmem_req = 1;
      tick(); tick();
      @(negedge clk); rst_n = 0; #1;
      checks++;
      if (ctl !== 6'b000000) begin errors++; $display("FAIL rst_mw_ctl got %b want 000000", ctl); end
      dmem_req = 0;
      @(negedge clk); rst_n = 1;
      tick();
      checks++;
      if (ctl !== 6'b000000) begin errors++; $display("FAIL rst_mw_after got %b want 000000", ctl); end
      set_lduse(5'd3);
      tick();
      @(negedge clk); rst_n = 0;
      @(negedge clk); rst_n = 1;
      #1;
      checks++;
      if (ctl !== 6'b110001) begin errors++; $display("FAIL rst_ld_after got %b want 110001", ctl); end
      tick(); idle(); tick();
   endtask

   task automatic test_saturation();
      idle();
      clear_cnt();
      set_lduse(5'd8);
      repeat (40) tick();
      checks++;
      if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_cnt got %0d want 15", stall_cnt); end
      cnt_clr = 1; #1;
      checks++;
      if (stall_if !== 1'b1) begin errors++; $display("FAIL sat_stall got %b want 1", stall_if); end
      tick();
      checks++;
      if (stall_cnt !== 4'd0) begin errors++; $display("FAIL clr_prio got %0d want 0", stall_cnt); end
      idle(); tick();
   endtask

   initial begin
      idle();
      rst_n = 0;
      test_reset();
      test_load_use();
      test_forward();
      test_memwait();
      test_redirect_lduse();
      test_timeout();
      test_reset_abandon();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
